// File: rtl/magtan_arb.sv
// Two-requester round-robin front end for a shared fixed-latency gradient
// magnitude/direction unit, with credit-guarded per-requester result FIFOs.

module magtan_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [19:0] i_data,
    input  logic        i_pop,
    output logic        o_valid,
    output logic [19:0] o_data
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [19:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (i_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
endmodule

module magtan_arb #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    output logic        o_a_ready,
    input  logic [15:0] i_a_dx,
    input  logic [15:0] i_a_dy,
    input  logic        i_b_valid,
    output logic        o_b_ready,
    input  logic [15:0] i_b_dx,
    input  logic [15:0] i_b_dy,
    output logic [15:0] o_mt_dx,
    output logic [15:0] o_mt_dy,
    input  logic [15:0] i_mt_mag,
    input  logic [3:0]  i_mt_tan,
    output logic        o_ra_valid,
    input  logic        i_ra_ready,
    output logic [15:0] o_ra_mag,
    output logic [3:0]  o_ra_tan,
    output logic        o_rb_valid,
    input  logic        i_rb_ready,
    output logic [15:0] o_rb_mag,
    output logic [3:0]  o_rb_tan,
    output logic        o_busy
);
    // Credit is 4 bits; one more bit only when DEPTH itself needs it.
    localparam int CW = (DEPTH >= 16) ? 5 : 4;

    logic [1:0][CW-1:0] r_cred;
    logic               r_last_b;
    logic [LAT:1]       r_vld_pipe;
    logic [LAT:1]       r_id_pipe;
    logic [15:0]        r_mt_dx;
    logic [15:0]        r_mt_dy;

    logic [1:0]         w_valid;
    logic [1:0]         w_elig;
    logic [1:0]         w_grant;
    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic [1:0]         w_rready;
    logic [1:0]         w_fvalid;
    logic [1:0][19:0]   w_head;

    assign w_valid  = {i_b_valid, i_a_valid};
    assign w_rready = {i_rb_ready, i_ra_ready};
    assign w_elig   = {w_valid[1] && (r_cred[1] != '0), w_valid[0] && (r_cred[0] != '0)};

    // Readies are masked while reset is held so nothing looks accepted.
    assign w_grant[0] = i_rst && w_elig[0] && (!w_elig[1] || r_last_b);
    assign w_grant[1] = i_rst && w_elig[1] && (!w_elig[0] || !r_last_b);

    assign w_push[0] = r_vld_pipe[LAT] && !r_id_pipe[LAT];
    assign w_push[1] = r_vld_pipe[LAT] &&  r_id_pipe[LAT];
    assign w_pop     = w_fvalid & w_rready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cred     <= {2{CW'(DEPTH)}};
            r_last_b   <= 1'b1;
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
            r_mt_dx    <= '0;
            r_mt_dy    <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                r_cred[i] <= r_cred[i] - CW'(w_grant[i]) + CW'(w_pop[i]);
            if (|w_grant) r_last_b <= w_grant[1];
            r_vld_pipe[1] <= |w_grant;
            r_id_pipe[1]  <= w_grant[1];
            for (int s = 2; s <= LAT; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_id_pipe[s]  <= r_id_pipe[s-1];
            end
            if (w_grant[0]) begin
                r_mt_dx <= i_a_dx;
                r_mt_dy <= i_a_dy;
            end else if (w_grant[1]) begin
                r_mt_dx <= i_b_dx;
                r_mt_dy <= i_b_dy;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        magtan_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[g]),
            .i_data  ({i_mt_mag, i_mt_tan}),
            .i_pop   (w_pop[g]),
            .o_valid (w_fvalid[g]),
            .o_data  (w_head[g])
        );
    end

    assign o_a_ready  = w_grant[0];
    assign o_b_ready  = w_grant[1];
    assign o_mt_dx    = r_mt_dx;
    assign o_mt_dy    = r_mt_dy;
    assign o_ra_valid = w_fvalid[0];
    assign o_ra_mag   = w_head[0][19:4];
    assign o_ra_tan   = w_head[0][3:0];
    assign o_rb_valid = w_fvalid[1];
    assign o_rb_mag   = w_head[1][19:4];
    assign o_rb_tan   = w_head[1][3:0];
    assign o_busy     = (|r_vld_pipe) || (|w_fvalid);
endmodule

// File: tb/tb_magtan_arb.sv
// Directed + random bench for magtan_arb with a queue scoreboard per requester
// and a fixed-latency behavioural model of the shared magnitude unit.

module tb_magtan_arb;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_dx, a_dy, b_dx, b_dy;
    logic [15:0] mt_dx, mt_dy, mt_mag;
    logic [3:0]  mt_tan;
    logic        ra_valid, ra_ready, rb_valid, rb_ready;
    logic [15:0] ra_mag, rb_mag;
    logic [3:0]  ra_tan, rb_tan;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int acc_a = 0, acc_b = 0, pop_a = 0, pop_b = 0;
    logic [19:0] qa[$];
    logic [19:0] qb[$];
    logic [15:0] sa = 16'd0, sb = 16'd0;
    logic [19:0] mt_q;

    magtan_arb #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_dx(a_dx), .i_a_dy(a_dy),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_dx(b_dx), .i_b_dy(b_dy),
        .o_mt_dx(mt_dx), .o_mt_dy(mt_dy), .i_mt_mag(mt_mag), .i_mt_tan(mt_tan),
        .o_ra_valid(ra_valid), .i_ra_ready(ra_ready), .o_ra_mag(ra_mag), .o_ra_tan(ra_tan),
        .o_rb_valid(rb_valid), .i_rb_ready(rb_ready), .o_rb_mag(rb_mag), .o_rb_tan(rb_tan),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Alpha-max-beta-min magnitude; tan = {sx, sy, 0, |dy|>|dx|}.
    function automatic logic [19:0] model(input logic [15:0] dx, input logic [15:0] dy);
        logic [15:0] ax, ay, mx, mn;
        ax = dx[15] ? -dx : dx;
        ay = dy[15] ? -dy : dy;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        return {mx + (mn >> 1), dx[15], dy[15], 1'b0, ay > ax};
    endfunction

    // Shared unit at LAT=2: one register after the operand register.
    always @(posedge clk) mt_q <= model(mt_dx, mt_dy);
    assign mt_mag = mt_q[19:4];
    assign mt_tan = mt_q[3:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        logic [19:0] e;
        @(negedge clk);
        if (!rst) begin
            qa.delete();
            qb.delete();
        end else begin
            chk("one_ready", 32'(a_ready & b_ready), 0);
            chk("ready_wo_valid", 32'((a_ready & ~a_valid) | (b_ready & ~b_valid)), 0);
            if (a_valid && a_ready) begin qa.push_back(model(a_dx, a_dy)); acc_a++; end
            if (b_valid && b_ready) begin qb.push_back(model(b_dx, b_dy)); acc_b++; end
            if (ra_valid && ra_ready) begin
                pop_a++;
                chk("ra_expected", 32'(qa.size() != 0), 1);
                if (qa.size() != 0) begin e = qa.pop_front(); chk("ra_data", 32'({ra_mag, ra_tan}), 32'(e)); end
            end
            if (rb_valid && rb_ready) begin
                pop_b++;
                chk("rb_expected", 32'(qb.size() != 0), 1);
                if (qb.size() != 0) begin e = qb.pop_front(); chk("rb_data", 32'({rb_mag, rb_tan}), 32'(e)); end
            end
        end
    endtask

    task automatic drive_seq();
        a_dx = sa; a_dy = 16'd0; sa = sa + 16'd1;
        b_dx = 16'h4000 + sb; b_dy = 16'd0; sb = sb + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        sample();
        nxt();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        a_valid = 1'b0; b_valid = 1'b0; ra_ready = 1'b1; rb_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin sample(); nxt(); end
        sample();
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_qa_empty"}, qa.size(), 0);
        chk({tag, "_qb_empty"}, qb.size(), 0);
        nxt();
    endtask

    initial begin
        int na, nb, alt_err, base_a, base_b, bp_a, bp_b;
        logic prev_a;

        // Reset state with both requesters asking.
        rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1; ra_ready = 1'b0; rb_ready = 1'b0;
        a_dx = 16'h1234; a_dy = 16'h0055; b_dx = 16'h0777; b_dy = 16'h0003;
        nxt();
        sample();
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
        chk("rst_valids", 32'({ra_valid, rb_valid}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mt", 32'({mt_dx, mt_dy}), 0);
        chk("rst_heads", 32'({ra_mag, rb_mag}), 0);
        chk("rst_tans", 32'({ra_tan, rb_tan}), 0);
        nxt();
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;

        // Single sample, latency LAT+1.
        a_valid = 1'b1; a_dx = 16'd3; a_dy = 16'd4;
        sample();
        chk("t33_accept", 32'(a_ready), 1);
        nxt(); a_valid = 1'b0;
        sample();
        chk("t33_lat1", 32'(ra_valid), 0);
        chk("t33_busy", 32'(busy), 1);
        nxt();
        sample();
        chk("t33_lat2", 32'(ra_valid), 0);
        nxt();
        sample();
        chk("t33_valid", 32'(ra_valid), 1);
        chk("t33_result", 32'({ra_mag, ra_tan}), 32'({16'd5, 4'd1}));
        chk("t33_rb", 32'(rb_valid), 0);
        nxt(); ra_ready = 1'b1;
        sample();
        nxt(); ra_ready = 1'b0;
        sample();
        chk("t33_idle", 32'(busy), 0);
        nxt();

        // Round-robin alternation from reset.
        do_reset();
        ra_ready = 1'b1; rb_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        na = 0; nb = 0; alt_err = 0; prev_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_seq();
            sample();
            if (i == 0) chk("t34_first_A", 32'(a_ready), 1);
            if (a_ready == b_ready) alt_err++;
            if (i > 0 && a_ready == prev_a) alt_err++;
            prev_a = a_ready;
            if (a_ready) na++;
            if (b_ready) nb++;
            nxt();
        end
        chk("t34_alternate", alt_err, 0);
        chk("t34_a_share", na, 10);
        chk("t34_b_share", nb, 10);
        drain("t34");

        // A back-pressured: four accepts only, B at full rate.
        do_reset();
        ra_ready = 1'b0; rb_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        na = 0; nb = 0;
        for (int i = 0; i < 30; i++) begin
            drive_seq(); sample();
            if (a_ready) na++;
            if (b_ready) nb++;
            nxt();
        end
        chk("t35_a_accepts", na, DEPTH);
        chk("t35_b_accepts", nb, 30 - DEPTH);
        na = 0; ra_ready = 1'b1;
        drive_seq(); sample();
        if (a_ready) na++;
        nxt(); ra_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_seq(); sample();
            if (a_ready) na++;
            nxt();
        end
        chk("t35_one_more", na, 1);
        drain("t35");

        // FIFO at DEPTH-1, then simultaneous pop/write traffic.
        do_reset();
        base_a = acc_a; bp_a = pop_a;
        ra_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin drive_seq(); sample(); nxt(); end
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin sample(); nxt(); end
        chk("t36_prefill", acc_a - base_a, DEPTH - 1);
        ra_ready = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin drive_seq(); sample(); nxt(); end
        drain("t36");
        chk("t36_no_loss", pop_a - bp_a, acc_a - base_a);

        // Reset with 3 buffered and 2 in flight.
        do_reset();
        ra_ready = 1'b0; rb_ready = 1'b0; a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin drive_seq(); sample(); nxt(); end
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin sample(); nxt(); end
        b_valid = 1'b1;
        drive_seq(); sample(); nxt();
        drive_seq(); sample(); nxt();
        rst = 1'b0; b_valid = 1'b0; a_valid = 1'b1;
        sample();
        chk("t37_rst_valids", 32'({ra_valid, rb_valid}), 0);
        chk("t37_rst_busy", 32'(busy), 0);
        chk("t37_rst_ready", 32'({a_ready, b_ready}), 0);
        nxt();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        base_a = acc_a; base_b = acc_b; bp_a = pop_a; bp_b = pop_b;
        drive_seq(); sample();
        chk("t37_first_grant", 32'(a_ready), 1);
        nxt();
        for (int i = 0; i < 20; i++) begin drive_seq(); sample(); nxt(); end
        chk("t37_credit_a", acc_a - base_a, DEPTH);
        chk("t37_credit_b", acc_b - base_b, DEPTH);
        drain("t37");
        chk("t37_pops_a", pop_a - bp_a, DEPTH);
        chk("t37_pops_b", pop_b - bp_b, DEPTH);

        // Random traffic against the scoreboard.
        do_reset();
        base_a = acc_a; base_b = acc_b; bp_a = pop_a; bp_b = pop_b;
        for (int i = 0; i < 10000; i++) begin
            drive_seq();
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            ra_ready = 1'($urandom_range(0, 1));
            rb_ready = 1'($urandom_range(0, 1));
            sample();
            nxt();
        end
        drain("t38");
        chk("t38_count_a", pop_a - bp_a, acc_a - base_a);
        chk("t38_count_b", pop_b - bp_b, acc_b - base_b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
